// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - multi-cycle MIPS control FSM (lw, sw, R-type, addi, beq, j)
//
// Sequences the shared ALU, the unified memory port, the IR and the register
// file from the IR opcode. Memory accesses complete on mem_req && mem_ready.
// Counts retired instructions.
//
// Optional feature macro: MC_TRAP_EN (illegal opcode enters a sticky TRAP state).
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   opcode               IR[31:26], valid from DECODE onward
//   zero                 ALU zero flag (used by external PC logic with branch)
//   mem_ready            memory completes the pending access this cycle
//   mem_req, iord,       memory request, address select, write request
//   memwrite
//   irwrite, pcwrite,    IR load, PC load, conditional PC load, PC source
//   branch, pcsrc
//   alusrca, alusrcb,    ALU operand selects and operation
//   aluop
//   regdst, memtoreg,    register file destination, write-back source, write enable
//   regwrite
//   retired              retired-instruction count (RETIRE_W bits, wraps)
//   trap                 illegal-opcode trap
//   state_dbg            current state encoding (STATE_W bits)

module mips_multicycle_controller #(
    parameter int RETIRE_W = 32,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                memwrite,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                branch,
    output logic [1:0]          pcsrc,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [1:0]          aluop,
    output logic                regdst,
    output logic                memtoreg,
    output logic                regwrite,
    output logic [RETIRE_W-1:0] retired,
    output logic                trap,
    output logic [STATE_W-1:0]  state_dbg
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   retire_now;

    // The zero flag is combined with branch in the PC logic, not here.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXEC;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
`ifdef MC_TRAP_EN
                    default:      state_nxt = S_TRAP;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            // Only lw and sw reach MEMADR, so anything but sw is treated as lw.
            S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_ADDIEX: state_nxt = S_ADDIWB;
            S_ADDIWB: state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
`ifdef MC_TRAP_EN
            S_TRAP:   state_nxt = S_TRAP;
`else
            S_TRAP:   state_nxt = S_FETCH;
`endif
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Last cycle of every legal instruction; an sw ends when its write completes.
    always_comb begin
        case (state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire_now = 1'b1;
            S_MEMWR:                                       retire_now = mem_ready;
            default:                                       retire_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (retire_now) begin
                retired <= retired + RETIRE_W'(1);
            end
        end
    end

    // Moore decode; everything is forced low while rst_n is low so a reset
    // during a pending access drops mem_req immediately.
    always_comb begin
        mem_req   = 1'b0;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        branch    = 1'b0;
        pcsrc     = 2'b00;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        aluop     = 2'b00;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        trap      = 1'b0;
        state_dbg = '0;
        if (rst_n) begin
            state_dbg = STATE_W'(state);
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    // IR and PC advance only on the cycle the fetch completes.
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXEC: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: regwrite = 1'b1;
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
`ifdef MC_TRAP_EN
                S_TRAP: trap = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
